muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for MULT, MULTU, DIV and DIVU.
- Sits beside the single-cycle ALU. The decode/stall logic issues an op with start, then holds the pipeline while busy.
- Uses one shift-add / restoring-subtract step per clock over a shared LENGTH-bit datapath.
- Also services MTHI/MTLO writes; HI/LO feed MFHI/MFLO.

Parameters:
- LENGTH, 32, operand/HI/LO width; must be >= 2.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > LENGTH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  0 MULT, 1 MULTU, 2 DIV, 3 DIVU; sampled with start.
- a  in  LENGTH  rs operand; sampled with start.
- b  in  LENGTH  rt operand; sampled with start.
- hi_wr  in  1  MTHI strobe.
- lo_wr  in  1  MTLO strobe.
- wdata  in  LENGTH  MTHI/MTLO data.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse when result committed.
- div_by_zero  out  1  pulses with done when DIV/DIVU had b==0.
- hi  out  LENGTH  HI register.
- lo  out  LENGTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, internal regs=0. Asserting reset mid-operation discards the op with no done.
- States: IDLE, RUN, FIX, DONE.
  - IDLE/DONE + start -> RUN. Operands are latched: signed ops take magnitudes |a|,|b| and record the result sign. counter=LENGTH.
  - DIV/DIVU with b==0 -> DONE directly. hi/lo unchanged; div_by_zero=1 in the DONE cycle.
  - RUN: one iteration per cycle, counter-1. When counter reaches 1, the next edge goes to FIX.
  - FIX: applies sign correction, writes hi/lo on the exiting edge -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE, or -> RUN if start is present (back-to-back issue allowed).
- Latency: start sampled at edge 0 -> busy=1 in cycles 1..LENGTH+1; hi/lo new and done=1 in cycle LENGTH+2. This is 34 cycles for LENGTH=32. The div-by-zero path has done in cycle 1.
- start while busy is ignored; no queuing.
- Multiply:
  - {hi,lo} = full 2*LENGTH-bit product.
  - MULT: two's-complement signed; negated if sign(a)^sign(b).
  - MULTU: unsigned.
- Divide (restoring):
  - lo = quotient, hi = remainder.
  - Signed: quotient truncated toward zero, negative iff sign(a)^sign(b); remainder takes the sign of a.
  - INT_MIN / -1 gives lo=INT_MIN, hi=0 (magnitude wraps on negate). No flag is raised.
- hi_wr/lo_wr:
  - Take effect on the next edge when not busy; dropped while busy.
  - Simultaneous with start: the write lands, and the op result later overwrites it.
  - Simultaneous hi_wr and lo_wr both apply.
- Outputs hi/lo are registered and stable except on a commit edge or write edge.

Optional Feature:
- Macro: MULDIV_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in RUN or FIX -> IDLE on the next edge; hi/lo unchanged, no done. abort is ignored in IDLE/DONE. abort together with start in IDLE means start wins.
- Undefined: no abort port; an op, once accepted, always completes or is killed only by rst_n.

Test Plan:
- MULT a=7, b=0xFFFFFFFD -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then immediate back-to-back DIVU a=100, b=7 issued in the DONE cycle -> lo=14, hi=2, done 34 cycles later.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU with b=0 and hi/lo preloaded via MTHI=0x11, MTLO=0x22 -> done and div_by_zero in cycle 1, hi=0x11, lo=0x22.
- hi_wr mid-RUN with wdata=0x55 -> ignored, final hi from op. start pulsed mid-RUN -> ignored, single done.
- rst_n low at cycle 10 of an op -> hi=lo=0, busy=0 immediately, no done. With MULDIV_ABORT_EN, abort at cycle 10 -> IDLE, hi/lo retain previous values, no done.

Source files
------------

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair
// Optional abort input is compiled in when MULDIV_ABORT_EN is defined.
module muldiv_seq #(
    parameter int LENGTH = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [LENGTH-1:0] a,
    input  logic [LENGTH-1:0] b,
    input  logic              hi_wr,
    input  logic              lo_wr,
    input  logic [LENGTH-1:0] wdata,
`ifdef MULDIV_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [LENGTH-1:0] hi,
    output logic [LENGTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [LENGTH-1:0] acc;
    logic [LENGTH-1:0] mq;
    logic [LENGTH-1:0] opnd;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;

    logic                idle_like;
    logic                signed_op;
    logic                sign_a;
    logic                sign_b;
    logic [LENGTH-1:0]   mag_a;
    logic [LENGTH-1:0]   mag_b;
    logic [LENGTH:0]     addsub;
    logic [2*LENGTH-1:0] prod_fix;
    logic [LENGTH-1:0]   quo_fix;
    logic [LENGTH-1:0]   rem_fix;
    logic                kill;

    // acc holds the running high product / partial remainder, mq the
    // multiplier / dividend-quotient, opnd the multiplicand / divisor.
    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        signed_op = ~op[0];
        sign_a    = signed_op & a[LENGTH-1];
        sign_b    = signed_op & b[LENGTH-1];
        mag_a     = sign_a ? -a : a;
        mag_b     = sign_b ? -b : b;
        if (is_div)
            addsub = {acc, mq[LENGTH-1]} - {1'b0, opnd};
        else
            addsub = {1'b0, acc} + {1'b0, opnd};
        prod_fix  = neg_q ? -{acc, mq} : {acc, mq};
        quo_fix   = neg_q ? -mq : mq;
        rem_fix   = neg_r ? -acc : acc;
`ifdef MULDIV_ABORT_EN
        kill      = abort & ~idle_like;
`else
        kill      = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mq          <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (idle_like) begin
                if (hi_wr) hi <= wdata;
                if (lo_wr) lo <= wdata;
            end
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            is_div <= op[1];
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= sign_a;
                            acc    <= '0;
                            mq     <= mag_a;
                            opnd   <= mag_b;
                            cnt    <= CNT_W'(LENGTH);
                            if (op[1] && (b == '0)) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                div_by_zero <= 1'b1;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    RUN: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) state <= FIX;
                        if (is_div) begin
                            // Restoring step: keep the difference only when no borrow.
                            if (!addsub[LENGTH]) begin
                                acc <= addsub[LENGTH-1:0];
                                mq  <= {mq[LENGTH-2:0], 1'b1};
                            end else begin
                                acc <= {acc[LENGTH-2:0], mq[LENGTH-1]};
                                mq  <= {mq[LENGTH-2:0], 1'b0};
                            end
                        end else if (mq[0]) begin
                            {acc, mq} <= {addsub, mq[LENGTH-1:1]};
                        end else begin
                            {acc, mq} <= {1'b0, acc, mq[LENGTH-1:1]};
                        end
                    end
                    FIX: begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*LENGTH-1:LENGTH];
                            lo <= prod_fix[LENGTH-1:0];
                        end
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed vector bench for muldiv_seq
module tb_muldiv_seq;
    localparam int L = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [L-1:0] a = '0;
    logic [L-1:0] b = '0;
    logic         hi_wr = 1'b0;
    logic         lo_wr = 1'b0;
    logic [L-1:0] wdata = '0;
`ifdef MULDIV_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [L-1:0] hi;
    logic [L-1:0] lo;

    int cycle = 0;
    int t0 = 0;
    int n_done = 0;
    int n_tests = 0;
    int n_fail = 0;

    muldiv_seq #(.LENGTH(L), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
`ifdef MULDIV_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge clk) begin
        #1;
        if (done) n_done++;
    end

    typedef struct {
        logic [1:0]   op;
        logic [L-1:0] a;
        logic [L-1:0] b;
        logic [L-1:0] ehi;
        logic [L-1:0] elo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [L-1:0] x, input logic [L-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        t0    = cycle;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input int exp_busy, input logic exp_dbz, input string nm);
        int nb = 0;
        while (!done && (cycle - t0) < 100) begin
            if (busy) nb++;
            @(negedge clk);
        end
        if (busy) nb++;
        check({nm, "_lat"}, cycle - t0, exp_lat);
        check({nm, "_busy"}, nb, exp_busy);
        check({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    endtask

    task automatic write_hilo(input logic h, input logic l, input logic [L-1:0] d);
        hi_wr = h;
        lo_wr = l;
        wdata = d;
        @(negedge clk);
        hi_wr = 1'b0;
        lo_wr = 1'b0;
    endtask

    initial begin
        int d0;
        vecs[0] = '{2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[8] = '{2'd0, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB};
        vecs[9] = '{2'd3, 32'd5,        32'd10,       32'd5,        32'd0};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(34, 33, 1'b0, $sformatf("v%0d", i));
            check($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].elo);
            @(negedge clk);
        end

        write_hilo(1'b1, 1'b0, 32'h11);
        write_hilo(1'b0, 1'b1, 32'h22);
        issue(2'd3, 32'd5, 32'd0);
        wait_done(1, 0, 1'b1, "dbz");
        check("dbz_hi", hi, 32'h11);
        check("dbz_lo", lo, 32'h22);
        @(negedge clk);

        hi_wr = 1'b1;
        lo_wr = 1'b1;
        wdata = 32'h99;
        issue(2'd2, 32'd9, 32'd0);
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wait_done(1, 0, 1'b1, "wr_start");
        check("wr_start_hi", hi, 32'h99);
        check("wr_start_lo", lo, 32'h99);
        @(negedge clk);

        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(34, 33, 1'b0, "b2b_mul");
        check("b2b_mul_hi", hi, 32'hFFFFFFFE);
        check("b2b_mul_lo", lo, 32'h00000001);
        issue(2'd3, 32'd100, 32'd7);
        wait_done(34, 33, 1'b0, "b2b_div");
        check("b2b_div_hi", hi, 32'd2);
        check("b2b_div_lo", lo, 32'd14);
        @(negedge clk);

        d0 = n_done;
        issue(2'd1, 32'h00010000, 32'h00030000);
        repeat (5) @(negedge clk);
        hi_wr = 1'b1;
        wdata = 32'h55;
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd1;
        b     = 32'd0;
        @(negedge clk);
        hi_wr = 1'b0;
        start = 1'b0;
        wait_done(34, 27, 1'b0, "midrun");
        check("midrun_hi", hi, 32'h3);
        check("midrun_lo", lo, 32'h0);
        repeat (40) @(negedge clk);
        check("midrun_ndone", n_done - d0, 32'd1);

`ifdef MULDIV_ABORT_EN
        write_hilo(1'b1, 1'b0, 32'hAA);
        write_hilo(1'b0, 1'b1, 32'hBB);
        d0 = n_done;
        issue(2'd1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_ndone", n_done - d0, 32'd0);
        check("abort_hi", hi, 32'hAA);
        check("abort_lo", lo, 32'hBB);
        abort = 1'b1;
        issue(2'd0, 32'd7, 32'hFFFFFFFD);
        abort = 1'b0;
        wait_done(34, 33, 1'b0, "abort_start");
        check("abort_start_lo", lo, 32'hFFFFFFEB);
        @(negedge clk);
`endif

        d0 = n_done;
        issue(2'd1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_ndone", n_done - d0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
